npc_pc_unit: RTL and testbench
==============================

Name: npc_pc_unit

Overview:
- Program-counter stage of the single-cycle RV32I core; it sits directly downstream of the ALU.
- Consumes the ALU branch flag (bool) and result (JALR target), selects the next PC, and holds the architectural PC register.
- Feeds pc to instruction fetch and pc+4 to the writeback mux for JAL/JALR link.
- Adds stall hold, a misaligned-target trap with halt state, and a 64-bit retired-instruction counter.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- npc_op  in  2  next-PC select: 2'b00 SEQ, 2'b01 BR, 2'b10 JAL, 2'b11 JALR.
- imm  in  32  sign-extended immediate from the immediate generator (branch/JAL offset).
- alu_result  in  32  ALU result; the JALR target before alignment.
- alu_bool  in  1  ALU branch-condition flag.
- stall  in  1  hold the PC; the current instruction does not retire.
- pc  out  32  current PC (registered).
- pc4  out  32  pc + 4 (combinational); link value.
- npc  out  32  computed next PC (combinational).
- taken  out  1  redirect this cycle (combinational).
- trap  out  1  misaligned-target trap; registered and sticky.
- trap_pc  out  32  PC of the instruction that trapped (registered).
- instret  out  CNT_W  retired-instruction count (registered).

Behaviour:
- Reset (rst=1 at a clock edge) sets pc=RESET_VEC, state=RUN, trap=0, trap_pc=0, instret=0.
  - rst has priority over every other input, including in HALT.
  - Reset asserted mid-operation discards any pending redirect.
- Next-PC computation (combinational, zero latency); all adds are 32-bit modulo, no overflow flag:
  - SEQ: npc = pc + 4.
  - BR: npc = alu_bool ? pc + imm : pc + 4.
  - JAL: npc = pc + imm.
  - JALR: npc = alu_result & 32'hFFFF_FFFE, i.e. bit 0 cleared per RV32I.
  - taken = 1 for JAL and JALR, for BR when alu_bool=1, and 0 otherwise.
- Misalignment: mis = taken & npc[1]. SEQ never misaligns, because pc stays word-aligned.
- State machine, 2 states:
  - RUN, stall=1: pc, instret, trap and trap_pc all hold. mis is ignored while stalled.
  - RUN, stall=0, mis=0: pc <= npc and instret <= instret + 1.
  - RUN, stall=0, mis=1: pc holds, trap <= 1, trap_pc <= pc, go to HALT. instret does NOT increment, because the faulting instruction does not retire.
  - HALT: pc, trap_pc and instret are frozen; trap stays 1. Only rst leaves HALT, returning to RUN.
- pc wrap-around: pc=32'hFFFF_FFFC with SEQ gives pc=0, with no trap.
- instret wraps modulo 2^CNT_W silently.
- Latency: the npc decision is visible on pc exactly one edge after the instruction presents npc_op.
- npc and taken stay combinationally valid in HALT and while stalled, for debug only; they have no effect on state.

Decomposition:
- Shared defines header: NPC_SEQ, NPC_BR, NPC_JAL and NPC_JALR as 2-bit `define constants, alongside the existing ALU_Sel defines. The RESET_VEC default also lives there.
- Sub-module npc_calc: purely combinational. Its inputs are npc_op, pc, imm, alu_result and alu_bool; its outputs are npc, taken and mis.
- npc_pc_unit holds the registers: pc, state, trap, trap_pc and instret.

Test Plan:
- Reset then 3 cycles of SEQ -> pc steps 0 → 4 → 8 → 12 (0x0, 0x4, 0x8, 0xC); instret=3; pc4=0x10 in the last cycle; taken=0 throughout.
- pc=0x100, BR, imm=0xFFFF_FFF0 (−16), alu_bool=1 -> npc=0xF0, taken=1, next pc=0xF0. Repeat with alu_bool=0 -> next pc=0x104, taken=0.
- pc=0x20, JALR, alu_result=0x0000_1235 -> npc=0x1234, pc=0x1234 next cycle, pc4 during the JALR cycle=0x24, no trap.
- pc=0x40, JAL, imm=0x6 -> npc=0x46, mis=1; next edge: trap=1, trap_pc=0x40, pc stays 0x40, instret unchanged. 5 further cycles of SEQ -> everything frozen. Assert rst -> pc=RESET_VEC, trap=0, instret=0.
- pc=0x80, stall=1 for 2 cycles with JAL imm=0x10 -> pc stays 0x80 and instret holds. Drop stall -> pc=0x90, instret+1.
- pc=0xFFFF_FFFC, SEQ -> pc=0x0000_0000, no trap. rst asserted in the same cycle as a JAL redirect -> pc=RESET_VEC.

Source files
------------

// File: rtl/npc_pc_unit_pkg.sv
// Shared types and constants for the RV32I program-counter stage.
// Next-PC select encodings match the decoder's npc_op field.
package npc_pc_unit_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ  = 2'b00,
      NPC_BR   = 2'b01,
      NPC_JAL  = 2'b10,
      NPC_JALR = 2'b11
   } npc_op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] JALR_MASK         = 32'hFFFF_FFFE;

endpackage

// File: rtl/npc_pc_unit_npc_calc.sv
// Combinational next-PC selection: target, redirect flag and misalignment flag.
// Has no state; all adds are 32-bit modulo.
module npc_pc_unit_npc_calc
   import npc_pc_unit_pkg::*;
(
   input  logic [1:0]  npc_op,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] alu_result,
   input  logic        alu_bool,
   output logic [31:0] npc,
   output logic        taken,
   output logic        mis
);

   logic [31:0] pc_seq;
   logic [31:0] pc_rel;

   assign pc_seq = pc + 32'd4;
   assign pc_rel = pc + imm;

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      npc   = pc_seq;
      taken = 1'b0;
      case (npc_op_e'(npc_op))
         NPC_SEQ: begin
            npc   = pc_seq;
            taken = 1'b0;
         end
         NPC_BR: begin
            npc   = alu_bool ? pc_rel : pc_seq;
            taken = alu_bool;
         end
         NPC_JAL: begin
            npc   = pc_rel;
            taken = 1'b1;
         end
         NPC_JALR: begin
            npc   = alu_result & JALR_MASK;
            taken = 1'b1;
         end
         default: begin
            npc   = pc_seq;
            taken = 1'b0;
         end
      endcase
   end

   // Only redirects can misalign; sequential flow keeps pc word-aligned.
   assign mis = taken & npc[1];

endmodule

// File: rtl/npc_pc_unit.sv
// Program-counter register stage: holds pc, the trap/halt state and the retired-instruction count.
// Next-PC selection is delegated to npc_pc_unit_npc_calc.
module npc_pc_unit
   import npc_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
   parameter int          CNT_W     = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       npc_op,
   input  logic [31:0]      imm,
   input  logic [31:0]      alu_result,
   input  logic             alu_bool,
   input  logic             stall,
   output logic [31:0]      pc,
   output logic [31:0]      pc4,
   output logic [31:0]      npc,
   output logic             taken,
   output logic             trap,
   output logic [31:0]      trap_pc,
   output logic [CNT_W-1:0] instret
);

   state_e state_q;
   state_e state_nxt;
   logic   mis;
   logic   advance;
   logic   take_trap;

   npc_pc_unit_npc_calc u_npc_calc (
      .npc_op     (npc_op),
      .pc         (pc),
      .imm        (imm),
      .alu_result (alu_result),
      .alu_bool   (alu_bool),
      .npc        (npc),
      .taken      (taken),
      .mis        (mis)
   );

   assign pc4 = pc + 32'd4;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_RUN:  if (!stall && mis) state_nxt = ST_HALT;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_RUN;
      endcase
   end

   // A stalled instruction neither retires nor traps, even if its target is misaligned.
   always_comb begin
      advance   = (state_q == ST_RUN) && !stall && !mis;
      take_trap = (state_q == ST_RUN) && !stall &&  mis;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_VEC;
         trap    <= 1'b0;
         trap_pc <= 32'h0000_0000;
         instret <= '0;
      end else begin
         if (advance) begin
            pc      <= npc;
            instret <= instret + CNT_W'(1);
         end
         if (take_trap) begin
            trap    <= 1'b1;
            trap_pc <= pc;
         end
      end
   end

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed self-checking bench for npc_pc_unit: sequential flow, branches, JALR,
// misaligned trap with halt, stall hold, pc wrap and reset priority.
module tb_npc_pc_unit;
   import npc_pc_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  npc_op;
   logic [31:0] imm;
   logic [31:0] alu_result;
   logic        alu_bool;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] npc;
   logic        taken;
   logic        trap;
   logic [31:0] trap_pc;
   logic [63:0] instret;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   npc_pc_unit #(
      .RESET_VEC (32'h0000_0000),
      .CNT_W     (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .npc_op     (npc_op),
      .imm        (imm),
      .alu_result (alu_result),
      .alu_bool   (alu_bool),
      .stall      (stall),
      .pc         (pc),
      .pc4        (pc4),
      .npc        (npc),
      .taken      (taken),
      .trap       (trap),
      .trap_pc    (trap_pc),
      .instret    (instret)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [31:0] i, input logic [31:0] ar, input logic b);
      npc_op     = op;
      imm        = i;
      alu_result = ar;
      alu_bool   = b;
      #1;
   endtask

   // Place pc at an aligned address through a JALR (retires one instruction).
   task automatic jump_to(input logic [31:0] target);
      drive(NPC_JALR, 32'h0, target, 1'b0);
      step();
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      drive(NPC_SEQ, 32'h0, 32'h0, 1'b0);
      step();
      step();
      rst = 1'b0;
      check("reset_pc", pc, 32'h0);
      check("reset_trap", trap, 1'b0);
      check("reset_trap_pc", trap_pc, 32'h0);
      check("reset_instret", instret, 64'd0);

      // Sequential flow 0 -> 4 -> 8 -> C
      drive(NPC_SEQ, 32'h0, 32'h0, 1'b0);
      check("seq0_npc", npc, 32'h4);
      check("seq0_taken", taken, 1'b0);
      step();
      check("seq1_pc", pc, 32'h4);
      step();
      check("seq2_pc", pc, 32'h8);
      step();
      check("seq3_pc", pc, 32'hC);
      check("seq3_instret", instret, 64'd3);
      check("seq3_pc4", pc4, 32'h10);
      check("seq3_taken", taken, 1'b0);

      // Taken backward branch
      jump_to(32'h100);
      check("br_setup_pc", pc, 32'h100);
      drive(NPC_BR, 32'hFFFF_FFF0, 32'h0, 1'b1);
      check("br_t_npc", npc, 32'hF0);
      check("br_t_taken", taken, 1'b1);
      step();
      check("br_t_pc", pc, 32'hF0);
      check("br_t_instret", instret, 64'd5);

      // Not-taken branch
      jump_to(32'h100);
      drive(NPC_BR, 32'hFFFF_FFF0, 32'h0, 1'b0);
      check("br_nt_npc", npc, 32'h104);
      check("br_nt_taken", taken, 1'b0);
      step();
      check("br_nt_pc", pc, 32'h104);

      // JALR clears bit 0
      jump_to(32'h20);
      drive(NPC_JALR, 32'h0, 32'h0000_1235, 1'b0);
      check("jalr_npc", npc, 32'h1234);
      check("jalr_pc4", pc4, 32'h24);
      check("jalr_taken", taken, 1'b1);
      step();
      check("jalr_pc", pc, 32'h1234);
      check("jalr_trap", trap, 1'b0);
      check("jalr_instret", instret, 64'd9);

      // Misaligned JAL traps and halts
      jump_to(32'h40);
      check("mis_setup_instret", instret, 64'd10);
      drive(NPC_JAL, 32'h6, 32'h0, 1'b0);
      check("mis_npc", npc, 32'h46);
      check("mis_taken", taken, 1'b1);
      step();
      check("mis_trap", trap, 1'b1);
      check("mis_trap_pc", trap_pc, 32'h40);
      check("mis_pc", pc, 32'h40);
      check("mis_instret", instret, 64'd10);
      drive(NPC_SEQ, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) step();
      check("halt_pc", pc, 32'h40);
      check("halt_instret", instret, 64'd10);
      check("halt_trap", trap, 1'b1);
      check("halt_trap_pc", trap_pc, 32'h40);
      check("halt_npc", npc, 32'h44);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("unhalt_pc", pc, 32'h0);
      check("unhalt_trap", trap, 1'b0);
      check("unhalt_trap_pc", trap_pc, 32'h0);
      check("unhalt_instret", instret, 64'd0);

      // Stall holds pc and instret
      jump_to(32'h80);
      stall = 1'b1;
      drive(NPC_JAL, 32'h10, 32'h0, 1'b0);
      step();
      step();
      check("stall_pc", pc, 32'h80);
      check("stall_instret", instret, 64'd1);
      stall = 1'b0;
      step();
      check("unstall_pc", pc, 32'h90);
      check("unstall_instret", instret, 64'd2);

      // Misaligned target while stalled does not trap
      stall = 1'b1;
      drive(NPC_JAL, 32'h2, 32'h0, 1'b0);
      check("stall_mis_npc", npc, 32'h92);
      step();
      check("stall_mis_trap", trap, 1'b0);
      check("stall_mis_pc", pc, 32'h90);
      stall = 1'b0;

      // pc wraps from FFFF_FFFC to 0
      jump_to(32'hFFFF_FFFC);
      drive(NPC_SEQ, 32'h0, 32'h0, 1'b0);
      check("wrap_npc", npc, 32'h0);
      step();
      check("wrap_pc", pc, 32'h0);
      check("wrap_trap", trap, 1'b0);
      check("wrap_instret", instret, 64'd4);

      // Reset beats a simultaneous redirect
      jump_to(32'h200);
      drive(NPC_JAL, 32'h10, 32'h0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_jal_pc", pc, 32'h0);
      check("rst_jal_instret", instret, 64'd0);
      drive(NPC_SEQ, 32'h0, 32'h0, 1'b0);
      step();
      check("post_rst_pc", pc, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
